// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Consumer side of the ECP5 PLL. Runs on the free-running reference clock,
//   pulses the PLL RST input, waits for LOCK with a timeout, and requires LOCK
//   to be stable for a programmable number of cycles before releasing system
//   reset. Loss-of-lock and retry statistics are kept for diagnostics.
//
// Ports
//   clk           in   reference clock (same source as PLL clkin)
//   resetn        in   asynchronous active-low reset
//   locked        in   PLL LOCK, asynchronous to clk
//   stat_clr      in   synchronous pulse clearing lock_lost and both counters
//   pll_rst       out  PLL RST, active high, registered
//   sys_rst_n     out  system reset, active low, registered, glitch-free
//   lock_lost     out  sticky flag: lock dropped while in RUN
//   relock_count  out  RUN->PLL_RESET transitions, saturating
//   timeout_count out  WAIT_LOCK timeouts, saturating
//   state         out  0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic             stat_clr,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [1:0]       state
);

  // The shared cycle counter must reach the largest terminal value - 1.
  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                     : STABLE_CYCLES;
  localparam int unsigned MAX_LEN = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int unsigned TMR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [TMR_W-1:0]         cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     pll_rst_q, pll_rst_d;
  logic                     sys_rst_n_q, sys_rst_n_d;
  logic                     lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]         relock_count_q, relock_count_d;
  logic [CNT_W-1:0]         timeout_count_q, timeout_count_d;

  logic                     lock_s;
  logic                     relock_evt;
  logic                     timeout_evt;

  // Synchroniser for the asynchronous LOCK input; bit 0 is the first stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state logic. The counter is cleared on every transition so each
  // state measures its own dwell time from zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + TMR_W'(1);
    relock_evt  = 1'b0;
    timeout_evt = 1'b0;

    unique case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        // A lock seen in the final timeout cycle still wins over the retry.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = ST_PLL_RESET;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d    = ST_PLL_RESET;
          relock_evt = 1'b1;
        end
      end

      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered versions
    // change on the same edge as the state register.
    pll_rst_d   = (state_d == ST_PLL_RESET);
    sys_rst_n_d = (state_d == ST_RUN);
  end

  // Statistics: saturating counters; a clear in the same cycle as an event wins.
  always_comb begin
    lock_lost_d     = lock_lost_q;
    relock_count_d  = relock_count_q;
    timeout_count_d = timeout_count_q;

    if (stat_clr) begin
      lock_lost_d     = 1'b0;
      relock_count_d  = '0;
      timeout_count_d = '0;
    end else begin
      if (relock_evt) begin
        lock_lost_d = 1'b1;
        if (relock_count_q != '1) begin
          relock_count_d = relock_count_q + CNT_W'(1);
        end
      end
      if (timeout_evt && (timeout_count_q != '1)) begin
        timeout_count_d = timeout_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_PLL_RESET;
      cnt_q           <= '0;
      sync_q          <= '0;
      pll_rst_q       <= 1'b1;
      sys_rst_n_q     <= 1'b0;
      lock_lost_q     <= 1'b0;
      relock_count_q  <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sync_q          <= sync_d;
      pll_rst_q       <= pll_rst_d;
      sys_rst_n_q     <= sys_rst_n_d;
      lock_lost_q     <= lock_lost_d;
      relock_count_q  <= relock_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign lock_lost     = lock_lost_q;
  assign relock_count  = relock_count_q;
  assign timeout_count = timeout_count_q;
  assign state         = state_q;

endmodule
